// File: rtl/hub75_pkg.sv
// Shared writer-state and pixel types for hub75_frame_buffer.
// The gamma LUT function exists only when HUB75_FB_GAMMA_EN is defined.
package hub75_pkg;

  localparam int HUB75_BPP = 8;

  typedef enum logic [1:0] {
    WAIT_SOF,
    FILL,
    FULL
  } hub75_fb_wr_state_t;

  typedef logic [2:0][HUB75_BPP-1:0] hub75_pixel_t;

`ifdef HUB75_FB_GAMMA_EN
  // Square-law curve: v^2 / 2^bpp. Constant bpp folds this into a LUT.
  function automatic logic [15:0] hub75_gamma(input logic [15:0] v, input int bpp);
    logic [31:0] sq;
    sq = 32'(v) * 32'(v);
    return 16'(sq >> bpp);
  endfunction
`endif

endpackage

// File: rtl/hub75_fb_ram.sv
// One frame bank: single write port plus one registered read port, 1-cycle read latency.
// Contents are never reset; there is no flow control at this level.
module hub75_fb_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hub75_frame_buffer.sv
// Double-buffered RGB frame store: valid/ready writes fill the back bank, 1-cycle reads come from the front.
// Ready drops once a frame is complete until the scanner's frame_done swaps banks. Option: HUB75_FB_GAMMA_EN.
module hub75_frame_buffer
  import hub75_pkg::*;
#(
  parameter int HPIXEL_P = 64,
  parameter int VPIXEL_P = 64,
  parameter int BPP_P    = 8,
  localparam int FRAME_SIZE_P = HPIXEL_P * VPIXEL_P,
  localparam int ADDR_WIDTH_P = $clog2(FRAME_SIZE_P)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic                    i_wr_sof,
  input  logic [2:0][BPP_P-1:0]   i_wr_data,
  input  logic [ADDR_WIDTH_P-1:0] i_rd_addr,
  output logic [2:0][BPP_P-1:0]   o_rd_data,
  input  logic                    i_frame_done,
  output logic                    o_front_sel,
  output logic                    o_swap,
  output logic                    o_sof_err
);

  localparam int DW = 3 * BPP_P;
  localparam logic [ADDR_WIDTH_P-1:0] LAST_ADDR = ADDR_WIDTH_P'(FRAME_SIZE_P - 1);

  hub75_fb_wr_state_t      state, state_nxt;
  logic [ADDR_WIDTH_P-1:0] wr_addr, wr_addr_nxt, waddr;
  logic                    front_sel_nxt, swap_nxt, sof_err_nxt;
  logic                    xfer, we;

  assign xfer = i_wr_valid && o_wr_ready;

  always_comb begin
    state_nxt     = state;
    wr_addr_nxt   = wr_addr;
    front_sel_nxt = o_front_sel;
    swap_nxt      = 1'b0;
    sof_err_nxt   = o_sof_err;
    we            = 1'b0;
    waddr         = wr_addr;
    case (state)
      WAIT_SOF: begin
        if (xfer && i_wr_sof) begin
          we          = 1'b1;
          waddr       = '0;
          wr_addr_nxt = ADDR_WIDTH_P'(1);
          state_nxt   = FILL;
        end
      end
      FILL: begin
        if (xfer) begin
          we = 1'b1;
          if (i_wr_sof) begin
            waddr       = '0;
            wr_addr_nxt = ADDR_WIDTH_P'(1);
            sof_err_nxt = 1'b1;
          end else begin
            wr_addr_nxt = wr_addr + ADDR_WIDTH_P'(1);
            if (wr_addr == LAST_ADDR) state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (i_frame_done) begin
          front_sel_nxt = ~o_front_sel;
          swap_nxt      = 1'b1;
          wr_addr_nxt   = '0;
          state_nxt     = WAIT_SOF;
        end
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_SOF;
      wr_addr     <= '0;
      o_front_sel <= 1'b0;
      o_swap      <= 1'b0;
      o_sof_err   <= 1'b0;
      o_wr_ready  <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_addr     <= wr_addr_nxt;
      o_front_sel <= front_sel_nxt;
      o_swap      <= swap_nxt;
      o_sof_err   <= sof_err_nxt;
      o_wr_ready  <= (state_nxt != FULL);
    end
  end

  logic                    ram_we, ram_bank;
  logic [ADDR_WIDTH_P-1:0] ram_waddr;
  logic [DW-1:0]           ram_wdata;

`ifdef HUB75_FB_GAMMA_EN
  logic [2:0][BPP_P-1:0] gamma_dat;

  always_comb begin
    gamma_dat = '0;
    for (int c = 0; c < 3; c++) gamma_dat[c] = BPP_P'(hub75_gamma(16'(i_wr_data[c]), BPP_P));
  end

  // Bank index travels with the pixel so a swap on the same edge cannot misdirect it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we    <= 1'b0;
      ram_bank  <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we    <= we;
      ram_bank  <= ~o_front_sel;
      ram_waddr <= waddr;
      ram_wdata <= gamma_dat;
    end
  end
`else
  assign ram_we    = we;
  assign ram_bank  = ~o_front_sel;
  assign ram_waddr = waddr;
  assign ram_wdata = i_wr_data;
`endif

  logic [DW-1:0] rdata0, rdata1;

  hub75_fb_ram #(.DEPTH(FRAME_SIZE_P), .AW(ADDR_WIDTH_P), .DW(DW)) u_bank0 (
    .clk(clk), .we(ram_we && !ram_bank), .waddr(ram_waddr), .wdata(ram_wdata),
    .raddr(i_rd_addr), .rdata(rdata0)
  );

  hub75_fb_ram #(.DEPTH(FRAME_SIZE_P), .AW(ADDR_WIDTH_P), .DW(DW)) u_bank1 (
    .clk(clk), .we(ram_we && ram_bank), .waddr(ram_waddr), .wdata(ram_wdata),
    .raddr(i_rd_addr), .rdata(rdata1)
  );

  // Bank select is captured with the address, so a read in the swap cycle sees the old front.
  logic rd_vld, rd_sel, rd_oob;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld <= 1'b0;
      rd_sel <= 1'b0;
      rd_oob <= 1'b0;
    end else begin
      rd_vld <= 1'b1;
      rd_sel <= o_front_sel;
      rd_oob <= (32'(i_rd_addr) >= 32'(FRAME_SIZE_P));
    end
  end

  assign o_rd_data = (rd_vld && !rd_oob) ? (rd_sel ? rdata1 : rdata0) : '0;

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Self-checking bench for hub75_frame_buffer: array-based frame model plus a directed vector table.
module tb_hub75_frame_buffer;

  localparam int H  = 64;
  localparam int V  = 64;
  localparam int BPP = 8;
  localparam int FS = H * V;
  localparam int AW = 12;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  logic                wr_sof = 1'b0;
  logic [2:0][BPP-1:0] wr_data = '0;
  logic [AW-1:0]       rd_addr = '0;
  logic [2:0][BPP-1:0] rd_data;
  logic                frame_done = 1'b0;
  logic                front_sel, swap, sof_err;

  always #5 clk = ~clk;

  hub75_frame_buffer #(.HPIXEL_P(H), .VPIXEL_P(V), .BPP_P(BPP)) dut (
    .clk(clk), .rst(rst),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_sof(wr_sof), .i_wr_data(wr_data),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .i_frame_done(frame_done), .o_front_sel(front_sel), .o_swap(swap), .o_sof_err(sof_err)
  );

  // Reference model: two frame arrays, a front index and a frame position
  // (-1 = waiting for sof, FS = frame complete, else next pixel index).
  logic [23:0] mem   [2][FS];
  bit          known [2][FS];
  bit          m_front, m_ready, m_swap, m_err, m_rd_known;
  int          m_pos;
  logic [23:0] m_rd;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    bit            v, s, fd;
    logic [AW-1:0] ra;
    bit            e_ready, e_front, e_swap, e_chk;
    logic [23:0]   e_rd;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_front = 1'b0; m_pos = -1; m_ready = 1'b0; m_swap = 1'b0; m_err = 1'b0;
    m_rd = '0; m_rd_known = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_front_sel"}, 32'(front_sel), 32'd0);
    chk({tag, "_swap"}, 32'(swap), 32'd0);
    chk({tag, "_sof_err"}, 32'(sof_err), 32'd0);
  endtask

  // Drive one cycle, advance the model over the edge, compare 1ns after it.
  task automatic step(input bit v, input bit s, input logic [23:0] d, input logic [AW-1:0] ra, input bit fd);
    bit xfer, swap_now;
    wr_valid = v; wr_sof = s; wr_data = d; rd_addr = ra; frame_done = fd;
    @(posedge clk);
    xfer       = v && m_ready;
    swap_now   = (m_pos == FS) && fd;
    m_rd       = mem[m_front][ra];
    m_rd_known = known[m_front][ra];
    if (xfer && s) begin
      if (m_pos >= 0) m_err = 1'b1;
      mem[!m_front][0]   = d;
      known[!m_front][0] = 1'b1;
      m_pos = 1;
    end else if (xfer && m_pos >= 0) begin
      mem[!m_front][m_pos[AW-1:0]]   = d;
      known[!m_front][m_pos[AW-1:0]] = 1'b1;
      m_pos++;
    end
    if (swap_now) begin
      m_front = !m_front;
      m_pos   = -1;
    end
    m_swap  = swap_now;
    m_ready = (m_pos != FS);
    #1;
    chk("ready", 32'(wr_ready), 32'(m_ready));
    chk("front_sel", 32'(front_sel), 32'(m_front));
    chk("swap", 32'(swap), 32'(m_swap));
    chk("sof_err", 32'(sof_err), 32'(m_err));
    if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
  endtask

  initial begin
    logic [23:0] restart_d, fb5, d;
    int          swaps;

    // After frame A fills bank 1 and backpressure, front is 0 and the writer is FULL.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 12'h123, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 12'h123, 1'b1, 1'b1, 1'b0, 1'b1, 24'h232323};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 24'hFFFFFF};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000000};

    model_reset();
    #12;
    check_reset_outputs("por");
    rst = 1'b0;

    // Non-sof pixels before any frame are dropped.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 24'($urandom), AW'($urandom), 1'b0);

    // Frame A: data = addr[7:0], frame_done coincident with the last pixel.
    for (int i = 0; i < FS; i++)
      step(1'b1, i == 0, {3{8'(i)}}, AW'($urandom), i == FS - 1);
    chk("coincident_no_swap", 32'(swap), 32'd0);
    chk("full_ready_low", 32'(wr_ready), 32'd0);

    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 24'($urandom), AW'($urandom), 1'b0);
      chk("bp_ready", 32'(wr_ready), 32'd0);
      chk("bp_front", 32'(front_sel), 32'd0);
    end

    for (int i = 0; i < 4; i++) begin
      step(tbl[i].v, tbl[i].s, 24'hABCDEF, tbl[i].ra, tbl[i].fd);
      chk("tbl_ready", 32'(wr_ready), 32'(tbl[i].e_ready));
      chk("tbl_front", 32'(front_sel), 32'(tbl[i].e_front));
      chk("tbl_swap", 32'(swap), 32'(tbl[i].e_swap));
      if (tbl[i].e_chk) chk("tbl_rd_data", 32'(rd_data), 32'(tbl[i].e_rd));
    end

    // Whole displayed frame, which also exposes any write leaked during FULL.
    for (int a = 0; a < FS; a++) step(1'b0, 1'b0, 24'h0, AW'(a), 1'b0);

    // Frame B into bank 0 with an early restart at pixel 100.
    for (int i = 0; i < 100; i++) step(1'b1, i == 0, 24'($urandom), AW'($urandom), 1'b0);
    chk("sof_err_clear", 32'(sof_err), 32'd0);
    restart_d = 24'($urandom);
    step(1'b1, 1'b1, restart_d, AW'($urandom), 1'b0);
    chk("sof_err_set", 32'(sof_err), 32'd1);
    fb5 = '0;
    for (int i = 1; i < FS; i++) begin
      d = 24'($urandom) ^ 24'h800000;
      if (i == 5) fb5 = d;
      step(1'b1, 1'b0, d, AW'($urandom), 1'b0);
    end
    chk("b_full_ready", 32'(wr_ready), 32'd0);
    step(1'b0, 1'b0, 24'h0, AW'(5), 1'b0);

    // Read at swap: old bank in the swap cycle, new bank on the next.
    step(1'b0, 1'b0, 24'h0, AW'(5), 1'b1);
    chk("swap2_pulse", 32'(swap), 32'd1);
    chk("swap2_front", 32'(front_sel), 32'd0);
    chk("swap_cycle_old", 32'(rd_data), 32'h050505);
    step(1'b0, 1'b0, 24'h0, AW'(5), 1'b0);
    chk("after_swap_new", 32'(rd_data), 32'(fb5));
    step(1'b0, 1'b0, 24'h0, AW'(0), 1'b0);
    chk("restart_pixel0", 32'(rd_data), 32'(restart_d));
    chk("sof_err_sticky", 32'(sof_err), 32'd1);

    // Frame C abandoned by an asynchronous reset at pixel 2000.
    for (int i = 0; i < 2000; i++) step(1'b1, i == 0, 24'($urandom), AW'($urandom), 1'b0);
    #2;
    rst = 1'b1;
    wr_valid = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 24'($urandom), AW'($urandom), 1'b0);
    chk("post_rst_front", 32'(front_sel), 32'd0);

    // Randomised traffic with bubbles and stray frame_done pulses.
    swaps = 0;
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(3, 0) != 0, m_pos < 0, 24'($urandom), AW'($urandom),
           $urandom_range(7, 0) == 0);
      if (swap) swaps++;
    end
    chk("random_swaps_seen", 32'(swaps > 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
